insn_decode: RTL
================

INSN_DECODE -- requirements
Module: insn_decode

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid/in_ready (input/output, 1 each) and in_data (input, 32): fetch-side instruction-word handshake.
REQ-004 SHALL have ports: out_valid (output, 1) and out_ready (input, 1): controller-side handshake.
REQ-005 SHALL have decoded outputs: op[2:0], funct[3:0], immab, immlo[5:0], offset[9:0], ta1/ta2[5:0], tt1/tt2[1:0], endF, nalloc[6:0].
REQ-006 SHALL have prefix outputs: prefix_o[1:0], immhi_o[25:0], ta3_o/ta4_o[5:0], tt3_o/tt4_o[1:0].
REQ-007 SHALL have status outputs: icounter_o[6:0] (remaining fragment slots), frag_active (1), err_o (1, sticky).

Function
REQ-008 SHALL use field map in_data[31:29]=op; [28:25]=funct; [24]=immab; [23:18]=immlo; [17:12]=ta1/ta3; [11:10]=tt1/tt3; [9:4]=ta2/ta4; [3:2]=tt2/tt4; [9:0]=offset; [25:0]=immhi; [28]=endF; [6:0]=nalloc.
REQ-009 SHALL set in_ready = !out_valid || out_ready, combinationally.
REQ-010 SHALL register one accepted non-prefix word into the output stage; out_valid rises the cycle after acceptance (1-cycle latency); out_valid stays high and outputs stay stable until out_ready is sampled high.
REQ-011 SHALL consume op 100 (I prefix) without emitting it: latch immhi, set pending bit1.
REQ-012 SHALL consume op 011 (T prefix) without emitting it: latch ta3/tt3/ta4/tt4, set pending bit0.
REQ-013 SHALL encode prefix_o: 00 none, 10 I, 01 T, 11 both; a repeated prefix of the same type overwrites its fields.
REQ-014 SHALL copy pending prefix state into prefix_o/immhi_o/ta3_o/ta4_o/tt3_o/tt4_o when the next non-prefix word is accepted, clearing pending in that same cycle.
REQ-015 SHALL drive prefix_o=00 with the held prefix fields unchanged for non-prefixed instructions.
REQ-016 SHALL emit op 101, endF=0 (fragment start) downstream, load icounter_o=nalloc, and set frag_active.
REQ-017 SHALL decrement icounter_o by 1, saturating at 0, on each accepted op 000/001/010 word while frag_active.
REQ-018 SHALL emit op 101, endF=1 (fragment end) downstream, clear icounter_o and frag_active, and discard any pending prefix.
REQ-019 SHALL, when acceptance and output-drain happen in the same cycle, replace the output register with no bubble.

Reset
REQ-020 SHALL clear out_valid, pending prefix, prefix_o, immhi_o, ta3_o/ta4_o, tt3_o/tt4_o, all decoded outputs, icounter_o, frag_active, and err_o to 0 on rst.
REQ-021 SHALL give rst priority over any simultaneous handshake; the in-flight word is dropped.

Configuration
REQ-022 SHALL, with INSN_DECODE_ERR_EN defined, set err_o sticky on any of: op 110/111; op 000/001/010 accepted with frag_active=0 or icounter_o=0; a prefix immediately followed by op 101. Offending words are still emitted.
REQ-023 SHALL, without INSN_DECODE_ERR_EN, tie err_o to 0 and pass all words through with no checking logic.

Verification
REQ-024 SHALL verify: start nalloc=3, then ALU funct=0011 immlo=5 -> out_valid next cycle, funct=0011, immlo=5, icounter_o=2.
REQ-025 SHALL verify: I prefix immhi=0x155, then ALU -> a single output with prefix_o=10 and immhi_o=0x155; the following ALU gives prefix_o=00.
REQ-026 SHALL verify: T prefix ta3=7 tt3=10, then I prefix, then ALU -> prefix_o=11, ta3_o=7, tt3_o=10.
REQ-027 SHALL verify: out_ready held 0 for 4 cycles -> in_ready=0, outputs stable; out_ready=1 with in_valid=1 -> back-to-back transfer.
REQ-028 SHALL verify: fragment end after 1 instruction with nalloc=3 -> icounter_o=0, frag_active=0; then ALU -> err_o=1 (ERR_EN defined) or 0 (undefined).
REQ-029 SHALL verify: rst asserted while out_valid=1 with a pending prefix -> the next cycle has out_valid=0, prefix_o=00, icounter_o=0.

Source files
------------

// File: rtl/insn_decode.sv
// insn_decode: decodes instruction words, folds I/T prefixes into the next emitted word, tracks fragment slots; define INSN_DECODE_ERR_EN for sticky err_o checking
module insn_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  op,
    output logic [3:0]  funct,
    output logic        immab,
    output logic [5:0]  immlo,
    output logic [9:0]  offset,
    output logic [5:0]  ta1,
    output logic [5:0]  ta2,
    output logic [1:0]  tt1,
    output logic [1:0]  tt2,
    output logic        endF,
    output logic [6:0]  nalloc,
    output logic [1:0]  prefix_o,
    output logic [25:0] immhi_o,
    output logic [5:0]  ta3_o,
    output logic [5:0]  ta4_o,
    output logic [1:0]  tt3_o,
    output logic [1:0]  tt4_o,
    output logic [6:0]  icounter_o,
    output logic        frag_active,
    output logic        err_o
);
    logic        w_acc, w_pre_i, w_pre_t, w_emit, w_frag, w_fend, w_alu;
    logic [2:0]  w_op;
    logic [1:0]  r_pend;
    logic [25:0] r_immhi;
    logic [15:0] r_tfld;

    assign in_ready = !out_valid || out_ready;
    assign w_acc    = in_valid && in_ready;
    assign w_op     = in_data[31:29];
    assign w_pre_i  = w_op == 3'b100;
    assign w_pre_t  = w_op == 3'b011;
    assign w_emit   = w_acc && !w_pre_i && !w_pre_t;
    assign w_frag   = w_op == 3'b101;
    assign w_fend   = w_frag && in_data[28];
    assign w_alu    = w_op < 3'b011;

    // output stage valid: set by an emitted word, dropped once drained
    always_ff @(posedge clk) begin
        if (rst) out_valid <= 1'b0;
        else if (w_emit) out_valid <= 1'b1;
        else if (out_ready) out_valid <= 1'b0;
    end

    // decoded field register, loaded only by emitted words
    always_ff @(posedge clk) begin
        if (rst) begin
            {op, funct, immab, immlo, offset, ta1, ta2, tt1, tt2, endF, nalloc} <= '0;
        end else if (w_emit) begin
            op     <= w_op;
            funct  <= in_data[28:25];
            immab  <= in_data[24];
            immlo  <= in_data[23:18];
            offset <= in_data[9:0];
            ta1    <= in_data[17:12];
            tt1    <= in_data[11:10];
            ta2    <= in_data[9:4];
            tt2    <= in_data[3:2];
            endF   <= in_data[28];
            nalloc <= in_data[6:0];
        end
    end

    // pending prefix capture; a repeat overwrites, any emitted word consumes them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_immhi <= '0;
            r_tfld  <= '0;
        end else if (w_acc) begin
            if (w_pre_i) begin
                r_pend[1] <= 1'b1;
                r_immhi   <= in_data[25:0];
            end
            if (w_pre_t) begin
                r_pend[0] <= 1'b1;
                r_tfld    <= in_data[17:2];
            end
            if (w_emit) r_pend <= '0;
        end
    end

    // prefix outputs: fields hold unless refreshed; a fragment end discards pending prefixes
    always_ff @(posedge clk) begin
        if (rst) begin
            prefix_o <= '0;
            immhi_o  <= '0;
            {ta3_o, tt3_o, ta4_o, tt4_o} <= '0;
        end else if (w_emit) begin
            prefix_o <= w_fend ? 2'b00 : r_pend;
            if (r_pend[1] && !w_fend) immhi_o <= r_immhi;
            if (r_pend[0] && !w_fend) {ta3_o, tt3_o, ta4_o, tt4_o} <= r_tfld;
        end
    end

    // fragment slot tracking: start loads nalloc, ALU ops consume one slot, end clears
    always_ff @(posedge clk) begin
        if (rst) begin
            icounter_o  <= '0;
            frag_active <= 1'b0;
        end else if (w_acc && w_frag) begin
            icounter_o  <= w_fend ? 7'd0 : in_data[6:0];
            frag_active <= !w_fend;
        end else if (w_acc && w_alu && frag_active && icounter_o != 7'd0) begin
            icounter_o <= icounter_o - 7'd1;
        end
    end

`ifdef INSN_DECODE_ERR_EN
    // sticky error: reserved op, ALU outside a live fragment, or prefix directly before a fragment marker
    always_ff @(posedge clk) begin
        if (rst) err_o <= 1'b0;
        else if (w_acc && (w_op[2:1] == 2'b11 || (w_alu && (!frag_active || icounter_o == 7'd0)) || (w_frag && r_pend != 2'b00))) err_o <= 1'b1;
    end
`else
    assign err_o = 1'b0;
`endif
endmodule
